// File: rtl/pwm_scan.sv
// Read-side sequencer for the double-buffered PWM threshold memory: sweeps the
// read address over each period, derives per-channel PWM levels, and requests swaps.
module pwm_scan #(
  parameter int pwm_width      = 16,
  parameter int num_pwm        = 4,
  parameter int prescale_width = 8,
  localparam int addr_width    = (pwm_width > 1) ? $clog2(pwm_width) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [prescale_width-1:0] prescale,
  input  logic [num_pwm-1:0]        invert,
  output logic [addr_width-1:0]     raddr,
  input  logic [num_pwm-1:0]        rdata,
  output logic                      latch_mem,
  output logic                      frame_start,
  output logic [num_pwm-1:0]        pwm_out
);

  localparam logic [addr_width-1:0] last_idx = addr_width'(pwm_width - 1);

  logic [addr_width-1:0]     step_q, step_d;
  logic [prescale_width-1:0] div_q, div_d;
  logic [prescale_width-1:0] pre_q, pre_d;
  logic [num_pwm-1:0]        off_seen_q, off_seen_d;
  logic [num_pwm-1:0]        pwm_q, pwm_d;

  logic                      run;
  logic                      tick;
  logic                      period_start;
  logic                      last_step;
  logic                      step_end;
  logic [prescale_width-1:0] pre_eff;
  logic [num_pwm-1:0]        base;
  logic [num_pwm-1:0]        hit;

  always_comb begin
    // Reset outranks enable for the combinational strobes too.
    run          = enable && !rst;
    tick         = run && (div_q == '0);
    period_start = tick && (step_q == '0);
    last_step    = (step_q == last_idx);
    // The prescale captured at period start governs the very first step as well.
    pre_eff      = period_start ? prescale : pre_q;
    step_end     = (div_q == pre_eff);
    base         = (step_q == '0) ? '0 : off_seen_q;
    hit          = base | rdata;

    raddr        = run ? step_q : '0;
    latch_mem    = run && last_step && (div_q == pre_q);
    frame_start  = period_start;
    pwm_out      = pwm_q;

    // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    step_d     = step_q;
    div_d      = div_q;
    pre_d      = pre_q;
    off_seen_d = off_seen_q;
    pwm_d      = pwm_q;

    if (!enable) begin
      step_d     = '0;
      div_d      = '0;
      off_seen_d = '0;
      pwm_d      = invert;
    end else begin
      if (period_start) begin
        pre_d = prescale;
      end
      if (step_end) begin
        div_d  = '0;
        step_d = last_step ? '0 : step_q + addr_width'(1);
      end else begin
        div_d  = div_q + prescale_width'(1);
      end
      if (tick) begin
        off_seen_d = hit;
        pwm_d      = ~hit ^ invert;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= '0;
      div_q      <= '0;
      pre_q      <= '0;
      off_seen_q <= '0;
      pwm_q      <= '0;
    end else begin
      step_q     <= step_d;
      div_q      <= div_d;
      pre_q      <= pre_d;
      off_seen_q <= off_seen_d;
      pwm_q      <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_scan.sv
// Self-checking bench for pwm_scan: a double-buffered memory model plus a
// duty-cycle reference model that predicts every output on every cycle.
module tb_pwm_scan;
  localparam int W = 16;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] prescale;
  logic [3:0] invert;
  logic [3:0] raddr;
  logic [3:0] rdata;
  logic       latch_mem;
  logic       frame_start;
  logic [3:0] pwm_out;

  logic [3:0] mem_act  [W];
  logic [3:0] mem_pend [W];
  logic       load_now;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_scan dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .prescale    (prescale),
    .invert      (invert),
    .raddr       (raddr),
    .rdata       (rdata),
    .latch_mem   (latch_mem),
    .frame_start (frame_start),
    .pwm_out     (pwm_out)
  );

  // Threshold memory: host fills the back buffer, the front buffer is read.
  assign rdata = mem_act[raddr];
  always @(posedge clk) begin
    if (latch_mem || load_now) mem_act <= mem_pend;
  end

  // Reference model: position within the period, period prescale, per-channel duty.
  int         m_pos = 0;
  int         m_pre = 0;
  int         m_duty [N];
  logic [3:0] m_pwm = '0;

  function automatic int duty_of(int c);
    for (int k = 0; k < W; k++) if (mem_act[k][c]) return k;
    return W;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_pre = 0; m_pwm = '0;
    end else if (!enable) begin
      m_pos = 0; m_pwm = invert;
    end else begin
      if (m_pos == 0) begin
        m_pre = int'(prescale);
        for (int c = 0; c < N; c++) m_duty[c] = duty_of(c);
      end
      if (m_pos % (m_pre + 1) == 0)
        for (int c = 0; c < N; c++)
          m_pwm[c] = logic'((m_pos / (m_pre + 1)) < m_duty[c]) ^ invert[c];
      m_pos = (m_pos + 1) % (W * (m_pre + 1));
    end
  end

  // Expected {raddr, latch_mem, frame_start, pwm_out} for the current cycle.
  function automatic logic [9:0] exp_vec();
    logic       on;
    logic [3:0] ra;
    on = enable && !rst;
    ra = (on && m_pos != 0) ? 4'(m_pos / (m_pre + 1)) : 4'd0;
    return {ra, on && (m_pos == W * (m_pre + 1) - 1), on && (m_pos == 0), m_pwm};
  endfunction

  task automatic load_front();
    load_now = 1'b1;
    @(negedge clk);
    load_now = 1'b0;
  endtask

  task automatic clear_pend();
    for (int k = 0; k < W; k++) mem_pend[k] = '0;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; prescale = 8'd0; invert = 4'b0000; load_now = 1'b0;
    clear_pend();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %b required 0", i, {raddr, latch_mem, frame_start, pwm_out});
      end
    end
    enable = 1'b0;
    load_front();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %b required %b", {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
    end
  endtask

  task automatic test_basic_duty();
    int hi0, hi3, lat;
    go_idle();
    clear_pend(); mem_pend[4] = 4'b0001; load_front();
    prescale = 8'd0; invert = 4'b0000; enable = 1'b1;
    hi0 = 0; hi3 = 0; lat = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL basic cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      hi0 += int'(pwm_out[0]); hi3 += int'(pwm_out[3]);
      if (latch_mem) begin
        lat++;
        n_checks++;
        if (raddr !== 4'd15) begin
          n_fail++;
          $display("FAIL basic_latch_addr: raddr %0d required 15", raddr);
        end
      end
    end
    n_checks++;
    if (hi0 != 8 || hi3 != 32 || lat != 2) begin
      n_fail++;
      $display("FAIL basic_counts: hi0 %0d hi3 %0d latch %0d required 8 32 2", hi0, hi3, lat);
    end
  endtask

  task automatic test_first_bit();
    int hi1, hi2;
    go_idle();
    clear_pend(); mem_pend[0] = 4'b0010; mem_pend[3] = 4'b0100; mem_pend[9] = 4'b0100; load_front();
    prescale = 8'd0; enable = 1'b1;
    hi1 = 0; hi2 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL first_bit cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
    end
    n_checks++;
    if (hi1 != 0 || hi2 != 3) begin
      n_fail++;
      $display("FAIL first_bit_counts: hi1 %0d hi2 %0d required 0 3", hi1, hi2);
    end
  endtask

  task automatic test_prescale();
    int hi0, frames, last_frame, gap;
    go_idle();
    clear_pend(); mem_pend[4] = 4'b0001; load_front();
    prescale = 8'd2; enable = 1'b1;
    hi0 = 0; frames = 0; last_frame = -1; gap = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL prescale cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      if (i < 48) hi0 += int'(pwm_out[0]);
      if (frame_start) begin
        frames++;
        if (last_frame >= 0) gap = i - last_frame;
        last_frame = i;
      end
      if (i == 21) prescale = 8'd0;
    end
    n_checks++;
    if (hi0 != 12 || frames != 3 || gap != 16) begin
      n_fail++;
      $display("FAIL prescale_counts: hi0 %0d frames %0d gap %0d required 12 3 16", hi0, frames, gap);
    end
  endtask

  task automatic test_buffer_swap();
    int hi_a, hi_b;
    go_idle();
    clear_pend(); mem_pend[4] = 4'b0001; load_front();
    prescale = 8'd0; invert = 4'b0000; enable = 1'b1;
    hi_a = 0; hi_b = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL swap cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      if (i < 16) hi_a += int'(pwm_out[0]); else hi_b += int'(pwm_out[0]);
      if (i == 15) begin
        n_checks++;
        if (raddr !== 4'd0 || frame_start !== 1'b1 || rdata !== 4'b0000) begin
          n_fail++;
          $display("FAIL swap_post_latch: raddr %0d frame %b rdata %b required 0 1 0000", raddr, frame_start, rdata);
        end
      end
      if (i == 7) begin
        clear_pend(); mem_pend[8] = 4'b0001;
      end
    end
    n_checks++;
    if (hi_a != 4 || hi_b != 8) begin
      n_fail++;
      $display("FAIL swap_counts: first %0d second %0d required 4 8", hi_a, hi_b);
    end
  endtask

  task automatic test_enable_invert();
    bit found;
    int lat;
    go_idle();
    invert = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (pwm_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_invert: pwm_out %b required 0001", pwm_out);
    end
    clear_pend(); mem_pend[4] = 4'b0001; load_front();
    prescale = 8'd0; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL enable cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      if (raddr == 4'd10) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL enable_reach_step10: timed out, raddr %0d required 10", raddr);
    end
    enable = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== {4'd0, 2'b00, invert}) begin
        n_fail++;
        $display("FAIL idle cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, {4'd0, 2'b00, invert});
      end
    end
    enable = 1'b1;
    #1;
    n_checks++;
    if (frame_start !== 1'b1 || raddr !== 4'd0) begin
      n_fail++;
      $display("FAIL reenable_frame: frame %b raddr %0d required 1 0", frame_start, raddr);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reenable cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      lat += int'(latch_mem);
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL reenable_latch_count: %0d required 1", lat);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; invert = 4'b1010;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({raddr, latch_mem, frame_start, pwm_out} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b required 0", {raddr, latch_mem, frame_start, pwm_out});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: frame %b required 1", frame_start);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int k = 0; k < W; k++) mem_pend[k] = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
    load_front();
    prescale = 8'($urandom_range(0, 3)); enable = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if ({raddr, latch_mem, frame_start, pwm_out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b required %b", i, {raddr, latch_mem, frame_start, pwm_out}, exp_vec());
      end
      if ($urandom_range(0, 9) == 0)
        mem_pend[$urandom_range(0, W - 1)] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) invert = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) prescale = 8'($urandom_range(0, 3));
      if (enable) begin
        if ($urandom_range(0, 149) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_first_bit();
    test_prescale();
    test_buffer_swap();
    test_enable_invert();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_scan.md
# pwm_scan

Read-side sequencer for the double-buffered PWM threshold memory. It sweeps the read address across the `pwm_width` time steps of each PWM period and samples the per-step channel threshold bits. From those bits it produces `num_pwm` registered PWM outputs. At the last cycle of every period it pulses `latch_mem`, so that a completed host update swaps in atomically at the period boundary.

## Interface
- `pwm_width`, 16: steps per PWM period, equal to the threshold-memory depth.
- `num_pwm`, 4: number of channels, equal to the threshold-memory data width.
- `prescale_width`, 8: width of the step prescaler.
- `clk` input 1: clock. One clock; every register in the block is on this clock.
- `rst` input 1: reset. Reset is synchronous and active-high.
- `enable` input 1: run the sequencer. Low holds the block idle.
- `prescale` input `prescale_width`: each step lasts `prescale`+1 clocks. Sampled only at period start.
- `invert` input `num_pwm`: per-channel output polarity. 1 means active-low.
- `raddr` output `$clog2(pwm_width)`: memory read address, equal to the current step.
- `rdata` input `num_pwm`: threshold bits at `raddr`. The memory read is combinational, so `rdata` is valid in the same cycle.
- `latch_mem` output 1: one-cycle pulse that requests a buffer swap at the period end.
- `frame_start` output 1: one-cycle pulse in the first cycle of every period.
- `pwm_out` output `num_pwm`: registered PWM outputs.

## Operation
- **Memory semantics:** bit c of the entry at step k set means channel c goes inactive at step k. Channel c is active from step 0 until the first step whose bit c is set.
- **Duty cycle:** the lowest set index k gives a duty of k/`pwm_width`.
  - Bit set at step 0 gives 0%.
  - No bit set in the period gives 100%.
  - Set bits after the first have no effect.
- **State:** `step` counter, `div` prescale counter, `pre_q` latched prescale, `off_seen` mask of channels already turned off.
- **Tick:** a cycle with `enable`=1 and `div`=0. On a tick:
  - `base` = 0 if `step`=0, otherwise `off_seen`.
  - `off_seen` <= `base` | `rdata`.
  - `pwm_out` <= ~(`base` | `rdata`) ^ `invert`.
- **Counting:**
  - `div` increments each enabled cycle and clears after reaching `pre_q`.
  - When `div` clears, `step` increments.
  - `step` wraps from `pwm_width`-1 to 0. `pwm_width` need not be a power of two; the wrap is explicit.
- **Prescale capture:** `pre_q` <= `prescale` in every cycle with `step`=0, `div`=0, `enable`=1. A `prescale` change mid-period takes effect at the next period start.
- **`raddr`:** equals `step` combinationally at all times, and reads 0 while idle.
- **`latch_mem`:** asserted in exactly the cycle with `enable`=1, `step`=`pwm_width`-1 and `div`=`pre_q`. The memory swaps on that edge, so the next step-0 tick reads the new buffer.
- **`frame_start`:** asserted in cycles with `enable`=1, `step`=0, `div`=0.
- **Idle (`enable`=0):**
  - `step`, `div` and `off_seen` are forced to 0.
  - `latch_mem` and `frame_start` are 0.
  - `pwm_out` <= `invert`, the inactive level.
- **Deassert mid-period:** counters clear on the next edge; the partial period is abandoned and no `latch_mem` is issued.
- **Re-enable:** the first enabled cycle is a step-0 tick with `frame_start`=1.
- **`invert` changes:** take effect at the next tick, or on the next cycle while idle.

## Timing
- **Reset values:** `step`=0, `div`=0, `pre_q`=0, `off_seen`=0, `pwm_out`=0, `raddr`=0, `latch_mem`=0, `frame_start`=0. `rst` has priority over `enable`.
- **Output latency:** `pwm_out` changes one clock after the tick edge of the step it reflects. Each step's output level holds for `prescale`+1 clocks.
- **Period length:** `pwm_width`×(`pre_q`+1) clocks. `latch_mem` and `frame_start` occur exactly once per period, in adjacent cycles: `latch_mem` then `frame_start`.
- **`prescale`=0:** every enabled cycle is a tick. `latch_mem` falls in the cycle with `step`=`pwm_width`-1.
- **Reset mid-period:** same result as idle, except `pwm_out`=0 rather than `invert`.
- **Simultaneous events:** `enable` falling in the `latch_mem` cycle suppresses `latch_mem`, because `latch_mem` is gated by `enable` combinationally.

## Test plan
- **Basic duty:** `prescale`=0, `invert`=0, memory with bit0 set only at step 4 → `pwm_out[0]` high for 4 clocks per 16-clock period. Channels with no bits set stay high continuously. `latch_mem` every 16 clocks at `raddr`=15.
- **0% and first-bit-wins:** bit1 set at step 0 → `pwm_out[1]` constantly 0. Bit2 set at steps 3 and 9 → high 3 clocks; the step-9 bit is ignored.
- **Prescale:** `prescale`=2 → period of 48 clocks and bit0 at step 4 gives 12 clocks high. Changing `prescale` to 0 at step 7 keeps 3-clock steps until the next `frame_start`, then 16-clock periods.
- **Buffer swap:** host writes bit0 at step 8 mid-period → current period still shows 4 clocks high. After `latch_mem` the next period shows 8 clocks high, and `raddr`=0 is read in the post-swap cycle.
- **Enable/invert:** `invert`=4'b0001 while idle → `pwm_out`=4'b0001. Drop `enable` at step 10 → `pwm_out`=`invert` next cycle and no `latch_mem`. Re-enable → `frame_start` in the first cycle and a full period follows.
- **Reset:** assert `rst` for 1 cycle while running → all outputs 0 and counters 0. If `enable` is held high, a fresh period starts in the following cycle.
